// File: rtl/matmul_mem_responder_if.sv
// Load/store request bus and host preload/readback port of the matmul word memory.
// The master is the multiply sequencer plus host; the slave is the memory responder.
interface matmul_mem_responder_if #(
   parameter int AW = 6
);
   logic          req_valid;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_done;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic [15:0]   txn_count;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [31:0]   host_wdata;
   logic [31:0]   host_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, host_we, host_addr, host_wdata,
      input  rsp_done, rsp_rdata, rsp_err, busy, txn_count, host_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, host_we, host_addr, host_wdata,
      output rsp_done, rsp_rdata, rsp_err, busy, txn_count, host_rdata
   );
endinterface

// File: rtl/matmul_mem_responder.sv
// Word memory slave for the matmul load/store bus: one request at a time, fixed latency,
// one-cycle rsp_done pulse. A host port preloads operands and reads back results.
//
// state   | meaning
// IDLE    | waiting for req_valid; request fields latched on accept
// WAIT    | latency down-counter running, busy high
// RESP    | rsp_done (and rsp_err on a bad address) for exactly this cycle
module matmul_mem_responder #(
   parameter int          DEPTH     = 64,
   parameter int          AW        = 6,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   matmul_mem_responder_if.slave bus
);
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_WAIT  = 2'd1;
   localparam logic [1:0]  ST_RESP  = 2'd2;
   localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic [1:0]    state_q, state_d;
   logic [3:0]    lat_cnt_q, lat_cnt_d;
   logic          we_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          err_q;
   logic [31:0]   rdata_q;
   logic [15:0]   txn_count_q;
   logic [31:0]   host_rdata_q;
   logic [31:0]   mem_q [DEPTH];

   logic [31:0]   word_off;
   logic          req_err;
   logic          accept;
   logic          enter_resp;
   logic          ent_we;
   logic [AW-1:0] ent_idx;
   logic [31:0]   ent_wdata;
   logic          ent_err;

   always_comb begin
      word_off = (bus.req_addr - BASE_ADDR) >> 2;
      req_err  = (bus.req_addr[1:0] != 2'b00) || (word_off >= DEPTH_W);
      accept   = (state_q == ST_IDLE) && bus.req_valid;
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               lat_cnt_d = LAT_LOAD;
               state_d   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q <= 4'd1) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // With LATENCY==1 the edge entering RESP is the accept edge, so use the live request.
   always_comb begin
      enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
      if (state_q == ST_IDLE) begin
         ent_we    = bus.req_we;
         ent_idx   = word_off[AW-1:0];
         ent_wdata = bus.req_wdata;
         ent_err   = req_err;
      end else begin
         ent_we    = we_q;
         ent_idx   = idx_q;
         ent_wdata = wdata_q;
         ent_err   = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lat_cnt_q    <= 4'd0;
         we_q         <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         err_q        <= 1'b0;
         rdata_q      <= 32'd0;
         txn_count_q  <= 16'd0;
         host_rdata_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         if (accept) begin
            we_q    <= bus.req_we;
            idx_q   <= word_off[AW-1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
         end
         if (enter_resp) begin
            if (ent_err)      rdata_q <= ERR_WORD;
            else if (!ent_we) rdata_q <= mem_q[ent_idx];
         end
         if ((state_q == ST_RESP) && (txn_count_q != 16'hFFFF))
            txn_count_q <= txn_count_q + 16'd1;
         host_rdata_q <= mem_q[bus.host_addr];
      end
   end

   // Transaction write is ordered after the host write so it wins a same-word collision.
   always_ff @(posedge clk) begin
      if (bus.host_we) mem_q[bus.host_addr] <= bus.host_wdata;
      if (enter_resp && !rst && ent_we && !ent_err) mem_q[ent_idx] <= ent_wdata;
   end

   assign bus.rsp_done   = (state_q == ST_RESP);
   assign bus.rsp_err    = (state_q == ST_RESP) && err_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.txn_count  = txn_count_q;
   assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_matmul_mem_responder.sv
// Bench for matmul_mem_responder: cycle-number reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_matmul_mem_responder;
   localparam int          DEPTH = 64;
   localparam int          AW    = 6;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   matmul_mem_responder_if #(.AW(AW)) bus ();

   matmul_mem_responder #(
      .DEPTH(DEPTH), .AW(AW), .LATENCY(LAT), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   logic [31:0] mem_m [DEPTH];
   bit          mem_k [DEPTH];
   int          cyc, idle_from, resp_cyc, acc_cyc, t_idx;
   bit          armed, t_we, t_err;
   logic [31:0] t_wdata, e_rdata, e_host;
   logic [15:0] e_cnt;
   bit          e_done, e_err, e_busy, e_rdata_k, e_host_k;

   initial begin
      logic [31:0] w;
      logic [31:0] nh;
      bit          nhk;
      armed = 0; cyc = 0; idle_from = 0; resp_cyc = -1; acc_cyc = -10;
      t_idx = 0; t_we = 0; t_err = 0; t_wdata = 0;
      e_done = 0; e_err = 0; e_busy = 0; e_rdata = 0; e_host = 0; e_cnt = 0;
      e_rdata_k = 1; e_host_k = 1;
      for (int i = 0; i < DEPTH; i++) mem_k[i] = 0;
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("rsp_done", 32'(bus.rsp_done), 32'(e_done));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("txn_count", 32'(bus.txn_count), 32'(e_cnt));
            if (e_rdata_k) chk("rsp_rdata", bus.rsp_rdata, e_rdata);
            if (e_host_k) chk("host_rdata", bus.host_rdata, e_host);
         end
         if (rst) begin
            armed = 1;
            idle_from = cyc + 1; resp_cyc = -1; acc_cyc = -10;
            e_done = 0; e_err = 0; e_busy = 0; e_rdata = 0; e_host = 0; e_cnt = 0;
            e_rdata_k = 1; e_host_k = 1;
            if (bus.host_we) begin
               mem_m[bus.host_addr] = bus.host_wdata;
               mem_k[bus.host_addr] = 1;
            end
         end else if (armed) begin
            nh  = mem_m[bus.host_addr];
            nhk = mem_k[bus.host_addr];
            if ((cyc == resp_cyc) && (e_cnt != 16'hFFFF)) e_cnt = e_cnt + 16'd1;
            if ((cyc >= idle_from) && bus.req_valid) begin
               w        = (bus.req_addr - BASE) >> 2;
               t_err    = (bus.req_addr[1:0] != 2'b00) || (w >= 32'(DEPTH));
               t_idx    = int'(w[AW-1:0]);
               t_we     = bus.req_we;
               t_wdata  = bus.req_wdata;
               acc_cyc  = cyc;
               resp_cyc = cyc + LAT;
               idle_from = resp_cyc + 1;
            end
            if (cyc + 1 == resp_cyc) begin
               if (t_err) begin
                  e_rdata = 32'hDEAD_BEEF; e_rdata_k = 1;
               end else if (!t_we) begin
                  e_rdata = mem_m[t_idx]; e_rdata_k = mem_k[t_idx];
               end
            end
            if (bus.host_we) begin
               mem_m[bus.host_addr] = bus.host_wdata;
               mem_k[bus.host_addr] = 1;
            end
            if ((cyc + 1 == resp_cyc) && t_we && !t_err) begin
               mem_m[t_idx] = t_wdata;
               mem_k[t_idx] = 1;
            end
            e_done   = (cyc + 1 == resp_cyc);
            e_err    = e_done && t_err;
            e_busy   = (cyc + 1 > acc_cyc) && (cyc + 1 <= resp_cyc);
            e_host   = nh;
            e_host_k = nhk;
         end
         cyc++;
      end
   end

   // ---------------- stimulus + literal expectations ----------------
   logic [31:0] pre_v [DEPTH];
   logic [8:0]  dmask, bmask;

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
   endtask

   initial begin
      int          r;
      logic [31:0] a;
      bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
      bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", 32'(bus.rsp_done), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_count", 32'(bus.txn_count), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         pre_v[i] = $urandom;
         bus.host_we = 1; bus.host_addr = AW'(i); bus.host_wdata = pre_v[i];
         tick();
      end
      bus.host_we = 1; bus.host_addr = 6'd3; bus.host_wdata = 32'h0001_0002;
      tick();
      bus.host_we = 0;

      // read word 3 with LATENCY=2
      issue(1'b0, 32'h0000_000C, 32'h0);
      @(negedge clk);
      chk("t1_c1_busy", 32'(bus.busy), 32'd1);
      chk("t1_c1_done", 32'(bus.rsp_done), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_c2_done", 32'(bus.rsp_done), 32'd1);
      chk("t1_c2_rdata", bus.rsp_rdata, 32'h0001_0002);
      chk("t1_c2_err", 32'(bus.rsp_err), 32'd0);
      chk("t1_c2_busy", 32'(bus.busy), 32'd1);
      tick();
      @(negedge clk);
      chk("t1_c3_done", 32'(bus.rsp_done), 32'd0);
      chk("t1_c3_busy", 32'(bus.busy), 32'd0);
      tick();

      // write word 4, read back over host port
      issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D);
      tick(); tick();
      bus.host_addr = 6'd4;
      tick();
      @(negedge clk);
      chk("t2_host_rdata", bus.host_rdata, 32'hCAFE_F00D);
      chk("t2_rdata_held", bus.rsp_rdata, 32'h0001_0002);
      tick();

      // misaligned and out-of-range reads
      issue(1'b0, 32'h0000_0006, 32'h0);
      tick();
      @(negedge clk);
      chk("t3a_done", 32'(bus.rsp_done), 32'd1);
      chk("t3a_err", 32'(bus.rsp_err), 32'd1);
      chk("t3a_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      tick();
      issue(1'b1, BASE + 32'(4 * DEPTH), 32'h5555_AAAA);
      tick();
      @(negedge clk);
      chk("t3b_err", 32'(bus.rsp_err), 32'd1);
      chk("t3b_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      tick();
      bus.host_addr = 6'd1;
      tick();
      @(negedge clk);
      chk("t3_word1_unchanged", bus.host_rdata, pre_v[1]);
      tick();

      // req_valid held high for nine cycles
      chk("t4_count_before", 32'(bus.txn_count), 32'd4);
      bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h0000_0008;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         dmask[i] = bus.rsp_done;
         bmask[i] = bus.busy;
         tick();
      end
      bus.req_valid = 0;
      @(negedge clk);
      chk("t4_done_cycles", 32'(dmask), 32'h124);
      chk("t4_busy_cycles", 32'(bmask), 32'h1B6);
      chk("t4_count_after", 32'(bus.txn_count), 32'd7);
      tick();

      // reset during a write
      bus.host_we = 1; bus.host_addr = 6'd7; bus.host_wdata = 32'h1234_5678;
      tick();
      bus.host_we = 0;
      issue(1'b1, 32'h0000_001C, 32'hBAD0_0BAD);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t5_done", 32'(bus.rsp_done), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_err", 32'(bus.rsp_err), 32'd0);
      chk("t5_rdata", bus.rsp_rdata, 32'd0);
      chk("t5_count", 32'(bus.txn_count), 32'd0);
      chk("t5_host_rdata", bus.host_rdata, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_word7_unchanged", bus.host_rdata, 32'h1234_5678);
      tick();

      // host and transaction write the same word on the same edge
      issue(1'b1, 32'h0000_0014, 32'h2222_2222);
      bus.host_we = 1; bus.host_addr = 6'd5; bus.host_wdata = 32'h1111_1111;
      tick();
      bus.host_we = 0;
      tick();
      @(negedge clk);
      chk("t6_collision", bus.host_rdata, 32'h2222_2222);
      tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 8)       a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
         else if (r == 8) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
         else             a = $urandom;
         bus.req_valid  = ($urandom_range(0, 2) != 0);
         bus.req_we     = $urandom_range(0, 1) == 1;
         bus.req_addr   = a;
         bus.req_wdata  = $urandom;
         bus.host_we    = ($urandom_range(0, 3) == 0);
         bus.host_addr  = AW'($urandom_range(0, DEPTH - 1));
         bus.host_wdata = $urandom;
         rst            = ($urandom_range(0, 299) == 0);
         tick();
      end
      bus.req_valid = 0; bus.host_we = 0; rst = 0;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
